pwm_duty_sequencer: RTL



---
 rtl/pwm_duty_sequencer.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/pwm_duty_sequencer.sv
// Duty-word sequencer feeding a W-bit PWM generator.
// Produces a static duty, a sawtooth ramp or a triangle ramp with end holds.
// Every duty/state change lands on the edge that closes a PWM frame.
module pwm_duty_sequencer #(
  parameter int W          = 4,
  parameter int FRAME_LEN  = 16,
  parameter int HOLD_STEPS = 2
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_en,
  input  logic [1:0]   i_mode,
  input  logic [2:0]   i_rate,
  input  logic [W-1:0] i_static_w,
  output logic [W-1:0] o_w,
  output logic         o_frame_tick,
  output logic         o_step_tick,
  output logic         o_dir
);
  localparam logic [W-1:0]   MAX       = {W{1'b1}};
  localparam int             FCW       = $clog2(FRAME_LEN);
  localparam int             HCW       = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
  localparam logic [FCW-1:0] FC_LAST   = FCW'(FRAME_LEN - 1);
  localparam logic [FCW-1:0] FC_PRE    = FCW'(FRAME_LEN - 2);
  localparam logic [HCW-1:0] HOLD_LAST = HCW'((HOLD_STEPS > 0) ? HOLD_STEPS - 1 : 0);

  typedef enum logic [2:0] {S_IDLE, S_UP, S_HOLD_TOP, S_DOWN, S_HOLD_BOT} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   w_q, w_d;
  logic [FCW-1:0] fc_q;
  logic           ft_q;
  logic [6:0]     psc_q, psc_d;
  logic [HCW-1:0] hold_q, hold_d;

  logic       fb, sb, run_req, saw;
  logic [6:0] step_lim;

  // ft_q is high exactly while fc_q sits on the last count, so it doubles as the
  // frame-boundary strobe.
  assign fb       = ft_q;
  assign step_lim = 7'((8'd1 << i_rate) - 8'd1);
  // ">=" so that lowering i_rate below the current count ends the step at once.
  assign sb       = fb && (psc_q >= step_lim);
  assign run_req  = i_en && ((i_mode == 2'b01) || (i_mode == 2'b10));
  assign saw      = (i_mode == 2'b01);

  // Free-running frame counter and registered frame tick.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      fc_q <= '0;
      ft_q <= 1'b0;
    end else begin
      fc_q <= (fc_q == FC_LAST) ? '0 : fc_q + 1'b1;
      ft_q <= (fc_q == FC_PRE);
    end
  end

  // Ramp state, duty word, step prescaler and hold counter.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      w_q     <= '0;
      psc_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      psc_q   <= psc_d;
      hold_q  <= hold_d;
    end
  end

  // Next-state: enable/mode checked every frame, ramp advances only on steps.
  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    psc_d   = psc_q;
    hold_d  = hold_q;
    if (fb) begin
      if (state_q == S_IDLE) begin
        psc_d = '0;
        if (run_req) begin
          state_d = S_UP;
          w_d     = '0;
        end else begin
          w_d = i_static_w;
        end
      end else if (!run_req) begin
        state_d = S_IDLE;
        w_d     = i_static_w;
        psc_d   = '0;
      end else begin
        psc_d = sb ? '0 : psc_q + 1'b1;
        if (sb) begin
          // Sawtooth pulls any falling/holding state back into UP, continuing
          // from the current word.
          if ((state_q == S_UP) || saw) begin
            state_d = S_UP;
            if (w_q != MAX) begin
              w_d = w_q + 1'b1;
            end else if (saw) begin
              w_d = '0;
            end else if (HOLD_STEPS > 0) begin
              state_d = S_HOLD_TOP;
              hold_d  = '0;
            end else begin
              state_d = S_DOWN;
              w_d     = MAX - 1'b1;
            end
          end else begin
            case (state_q)
              S_HOLD_TOP: begin
                if (hold_q == HOLD_LAST) begin
                  state_d = S_DOWN;
                  w_d     = MAX - 1'b1;
                end else begin
                  hold_d = hold_q + 1'b1;
                end
              end
              S_DOWN: begin
                if (w_q != '0) begin
                  w_d = w_q - 1'b1;
                end else if (HOLD_STEPS > 0) begin
                  state_d = S_HOLD_BOT;
                  hold_d  = '0;
                end else begin
                  state_d = S_UP;
                  w_d     = W'(1);
                end
              end
              S_HOLD_BOT: begin
                if (hold_q == HOLD_LAST) begin
                  state_d = S_UP;
                  w_d     = W'(1);
                end else begin
                  hold_d = hold_q + 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
      end
    end
  end

  assign o_w          = w_q;
  assign o_frame_tick = ft_q;
  assign o_step_tick  = sb && (state_q != S_IDLE);
  assign o_dir        = (state_q == S_UP) || (state_q == S_HOLD_TOP);

endmodule
